// File: rtl/pmodhb3_axi_lite_slave.sv
// pmodhb3_axi_lite_slave: AXI4-Lite responder exposing four 32-bit control registers
// with a one-cycle write-strobe pulse per register for the PmodHB3 H-bridge logic.
module pmodhb3_axi_lite_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] C_REG0_RST         = 32'h0
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic [3:0]                      reg_wr_stb
);
    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic [3:0][DW-1:0] regs_q, regs_d;
    logic               aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic               bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]         aw_idx_q, aw_idx_d;
    logic [DW-1:0]      w_data_q, w_data_d, rdata_q, rdata_d;
    logic [DW/8-1:0]    w_strb_q, w_strb_d;
    logic [3:0]         stb_q, stb_d;
    logic               aw_hs, w_hs, ar_hs, commit;
    logic               unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = ~aw_full_q & ~ARESET;
    assign S_AXI_WREADY  = ~w_full_q & ~ARESET;
    assign S_AXI_ARREADY = ~rvalid_q & ~ARESET;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg0_o        = regs_q[0];
    assign reg1_o        = regs_q[1];
    assign reg2_o        = regs_q[2];
    assign reg3_o        = regs_q[3];
    assign reg_wr_stb    = stb_q;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    // A buffered write only commits once the previous response has been accepted.
    assign commit = aw_full_q & w_full_q & ~bvalid_q;

    always_comb begin
        aw_full_d = aw_hs | (aw_full_q & ~commit);
        aw_idx_d  = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
        w_full_d  = w_hs | (w_full_q & ~commit);
        w_data_d  = w_hs ? S_AXI_WDATA : w_data_q;
        w_strb_d  = w_hs ? S_AXI_WSTRB : w_strb_q;
        bvalid_d  = commit | (bvalid_q & ~S_AXI_BREADY);
        rvalid_d  = ar_hs | (rvalid_q & ~S_AXI_RREADY);
        rdata_d   = ar_hs ? regs_q[S_AXI_ARADDR[3:2]] : rdata_q;
        stb_d     = commit ? 4'b0001 << aw_idx_q : 4'b0000;
        regs_d    = regs_q;
        for (int b = 0; b < DW/8; b++)
            regs_d[aw_idx_q][8*b +: 8] = (commit & w_strb_q[b]) ? w_data_q[8*b +: 8]
                                                                : regs_q[aw_idx_q][8*b +: 8];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q    <= {{(3*DW){1'b0}}, C_REG0_RST};
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            aw_idx_q  <= 2'b00;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rdata_q   <= '0;
            stb_q     <= 4'b0000;
        end else begin
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            aw_idx_q  <= aw_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            rdata_q   <= rdata_d;
            stb_q     <= stb_d;
        end
    end
endmodule

// File: tb/tb_pmodhb3_axi_lite_slave.sv
// tb_pmodhb3_axi_lite_slave: directed checks of the AXI4-Lite register slave.
module tb_pmodhb3_axi_lite_slave;
    localparam logic [31:0] R0RST = 32'hA5A5_0F0F;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWADDR, ARADDR;
    logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA, reg0, reg1, reg2, reg3;
    logic [3:0]  stb;
    int          checks = 0;
    int          failures = 0;

    pmodhb3_axi_lite_slave #(.C_REG0_RST(R0RST)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .reg_wr_stb(stb)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cur(input logic [1:0] i);
        return i == 2'd0 ? reg0 : i == 2'd1 ? reg1 : i == 2'd2 ? reg2 : reg3;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp_reg);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        chk("wr_readies", 32'({AWREADY, WREADY}), 32'h3);
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_readies_low", 32'({AWREADY, WREADY}), 32'h0);
        chk("wr_bvalid_early", 32'(BVALID), 32'h0);
        tick;
        chk("wr_bvalid", 32'(BVALID), 32'h1);
        chk("wr_bresp", 32'(BRESP), 32'h0);
        chk("wr_stb", 32'(stb), 32'h1 << a[3:2]);
        chk("wr_reg", cur(a[3:2]), exp_reg);
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
        chk("wr_bvalid_clr", 32'(BVALID), 32'h0);
        chk("wr_stb_clr", 32'(stb), 32'h0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        ARADDR = a; ARVALID = 1'b1;
        chk("rd_arready", 32'(ARREADY), 32'h1);
        tick;
        ARVALID = 1'b0;
        chk("rd_rvalid", 32'(RVALID), 32'h1);
        chk("rd_rdata", RDATA, exp);
        chk("rd_rresp", 32'(RRESP), 32'h0);
        chk("rd_arready_low", 32'(ARREADY), 32'h0);
        RREADY = 1'b1;
        tick;
        RREADY = 1'b0;
        chk("rd_rvalid_clr", 32'(RVALID), 32'h0);
    endtask

    initial begin
        ARESET = 1'b1; AWADDR = '0; ARADDR = '0; AWVALID = 0; WVALID = 0; BREADY = 0;
        ARVALID = 0; RREADY = 0; WDATA = '0; WSTRB = '0;
        tick; tick;
        chk("rst_readies", 32'({AWREADY, WREADY, ARREADY}), 32'h0);
        chk("rst_valids", 32'({BVALID, RVALID}), 32'h0);
        chk("rst_reg0", reg0, R0RST);
        chk("rst_reg1", reg1, 32'h0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_stb", 32'(stb), 32'h0);
        ARESET = 1'b0;
        tick;
        chk("idle_readies", 32'({AWREADY, WREADY, ARREADY}), 32'h7);

        wr(4'h0, 32'h0101FFFF, 4'hF, 32'h0101FFFF);
        rd(4'h0, 32'h0101FFFF);
        wr(4'h4, 32'hABCD0001, 4'hF, 32'hABCD0001);
        rd(4'h4, 32'hABCD0001);
        wr(4'h8, 32'hDEAD0011, 4'hF, 32'hDEAD0011);
        rd(4'h8, 32'hDEAD0011);
        wr(4'hC, 32'hBEEF0011, 4'hF, 32'hBEEF0011);
        rd(4'hC, 32'hBEEF0011);
        chk("all_reg0", reg0, 32'h0101FFFF);
        chk("all_reg1", reg1, 32'hABCD0001);
        chk("all_reg2", reg2, 32'hDEAD0011);
        chk("all_reg3", reg3, 32'hBEEF0011);
        rd(4'h3, 32'h0101FFFF);

        // W three cycles ahead of AW, sparse strobes
        WDATA = 32'hFFFFFFFF; WSTRB = 4'b0101; WVALID = 1'b1;
        tick;
        WVALID = 1'b0;
        chk("wfirst_wready", 32'(WREADY), 32'h0);
        chk("wfirst_awready", 32'(AWREADY), 32'h1);
        tick; tick;
        chk("wfirst_reg_hold", reg1, 32'hABCD0001);
        AWADDR = 4'h4; AWVALID = 1'b1;
        tick;
        AWVALID = 1'b0;
        chk("wfirst_bv_n1", 32'(BVALID), 32'h0);
        tick;
        chk("wfirst_bv_n2", 32'(BVALID), 32'h1);
        chk("wfirst_reg1", reg1, 32'hABFF00FF);
        chk("wfirst_stb", 32'(stb), 32'h2);
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
        rd(4'h4, 32'hABFF00FF);

        // Second write buffered behind an unaccepted response
        AWADDR = 4'h4; WDATA = 32'h11112222; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        tick;
        chk("bp_bv", 32'(BVALID), 32'h1);
        chk("bp_reg1", reg1, 32'h11112222);
        AWADDR = 4'h0; WDATA = 32'h33334444; AWVALID = 1'b1; WVALID = 1'b1;
        chk("bp_readies_open", 32'({AWREADY, WREADY}), 32'h3);
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("bp_readies_shut", 32'({AWREADY, WREADY}), 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_reg0_hold", reg0, 32'h0101FFFF);
            chk("bp_bv_hold", 32'(BVALID), 32'h1);
            chk("bp_stb_quiet", 32'(stb), 32'h0);
            tick;
        end
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
        chk("bp_bv_accepted", 32'(BVALID), 32'h0);
        chk("bp_reg0_not_yet", reg0, 32'h0101FFFF);
        tick;
        chk("bp_bv_second", 32'(BVALID), 32'h1);
        chk("bp_reg0_new", reg0, 32'h33334444);
        chk("bp_stb_second", 32'(stb), 32'h1);
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
        chk("bp_bv_clr", 32'(BVALID), 32'h0);
        tick;
        chk("bp_no_extra_bv", 32'(BVALID), 32'h0);

        // Read racing a commit to the same register
        AWADDR = 4'h8; WDATA = 32'h12345678; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 4'h8; ARVALID = 1'b1;
        tick;
        ARVALID = 1'b0;
        chk("race_rvalid", 32'(RVALID), 32'h1);
        chk("race_rdata_old", RDATA, 32'hDEAD0011);
        chk("race_bvalid", 32'(BVALID), 32'h1);
        chk("race_reg2", reg2, 32'h12345678);
        RREADY = 1'b1; BREADY = 1'b1;
        tick;
        RREADY = 1'b0; BREADY = 1'b0;
        chk("race_clr", 32'({BVALID, RVALID}), 32'h0);
        rd(4'h9, 32'h12345678);

        // Reset with both responses pending and a write buffered
        AWADDR = 4'hC; WDATA = 32'h0BADF00D; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'h0; ARVALID = 1'b1;
        tick;
        ARVALID = 1'b0;
        AWADDR = 4'h4; WDATA = 32'hCAFEBABE;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("prerst_valids", 32'({BVALID, RVALID}), 32'h3);
        chk("prerst_rdata", RDATA, 32'h33334444);
        chk("prerst_reg3", reg3, 32'h0BADF00D);
        ARESET = 1'b1;
        tick;
        chk("rst2_valids", 32'({BVALID, RVALID}), 32'h0);
        chk("rst2_readies_forced", 32'({AWREADY, WREADY, ARREADY}), 32'h0);
        chk("rst2_rdata", RDATA, 32'h0);
        chk("rst2_reg0", reg0, R0RST);
        chk("rst2_reg1", reg1, 32'h0);
        chk("rst2_reg2", reg2, 32'h0);
        chk("rst2_reg3", reg3, 32'h0);
        ARESET = 1'b0;
        tick; tick; tick;
        chk("rst2_no_stale_b", 32'(BVALID), 32'h0);
        chk("rst2_no_stale_r", 32'(RVALID), 32'h0);
        chk("rst2_stb", 32'(stb), 32'h0);
        rd(4'h0, R0RST);
        rd(4'h4, 32'h0);
        rd(4'h8, 32'h0);
        rd(4'hC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
